// File: rtl/uart_tx_feeder_pkg.sv
// Shared UART timing defaults, frame-length derivation and feeder FSM state encoding.
// The bit-timing defaults match the transmitter so both sides agree on frame length.
package uart_tx_feeder_pkg;

   localparam int BAUD_END_DEF = 5208;
   localparam int BIT_END_DEF  = 10;
   localparam int GAP_BITS_DEF = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SEND = 2'd2,
      WAIT = 2'd3
   } state_t;

   // Clock cycles from one frame start until the line may carry the next frame.
   function automatic int frame_cycles(input int baud_end, input int bit_end, input int gap_bits);
      return baud_end * (bit_end + gap_bits);
   endfunction

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Single-clock FIFO with registered read data (valid the cycle after rd_en).
// Pointers wrap naturally; level carries one extra bit so a full FIFO is representable.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             push;
   logic             pop;

   assign full  = (level == (AW + 1)'(DEPTH));
   assign empty = (level == '0);
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;

   // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves level unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   level <= level + (AW + 1)'(1);
            2'b01:   level <= level - (AW + 1)'(1);
            default: level <= level;
         endcase
      end
   end

   // Storage array and registered head read; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wr_data;
      if (pop)  rd_data   <= mem[rptr];
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte buffer and frame pacer in front of a UART transmitter that has no busy output.
// Pops one byte per frame, presents it on tx_data, pulses tx_flag once, then waits
// out a full frame plus idle gap before the next byte may start.
module uart_tx_feeder
   import uart_tx_feeder_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int BAUD_END = BAUD_END_DEF,
   parameter int BIT_END  = BIT_END_DEF,
   parameter int GAP_BITS = GAP_BITS_DEF
) (
   input  logic                     sclk,
   input  logic                     s_rst,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     tx_flag,
   output logic [7:0]               tx_data,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int FRAME_CYCLES = frame_cycles(BAUD_END, BIT_END, GAP_BITS);
   localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic             pop;
   logic [7:0]       head;
   logic             full;
   logic             empty;
   logic [CNT_W-1:0] cnt;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (sclk),
      .rst     (s_rst),
      .wr_en   (in_valid),
      .wr_data (in_data),
      .rd_en   (pop),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

   // Full blocks writes even if a pop lands in the same cycle, so overflow is impossible.
   assign in_ready = !full;
   assign busy     = (state != IDLE);

   // FSM state register.
   always_ff @(posedge sclk) begin
      if (s_rst) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; the head is popped on leaving IDLE so it is readable during LOAD.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               state_next = LOAD;
            end
         end
         LOAD:    state_next = SEND;
         SEND:    state_next = WAIT;
         WAIT:    if (cnt == '0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output byte, start pulse and frame pacing counter.
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         tx_flag <= 1'b0;
         tx_data <= 8'h00;
         cnt     <= '0;
      end else begin
         tx_flag <= (state == SEND);
         if (state == LOAD) tx_data <= head;
         if (state == SEND)
            cnt <= CNT_LOAD;
         else if ((state == WAIT) && (cnt != '0))
            cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with BAUD_END=8, BIT_END=10, GAP_BITS=1 (88-cycle frames), DEPTH=4.
// Cycle t of a scenario is the clock period after the t-th rising edge from its start;
// a byte driven in cycle 0 is captured at the following edge.
module tb_uart_tx_feeder;

   logic       sclk;
   logic       s_rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       tx_flag;
   logic [7:0] tx_data;
   logic       busy;
   logic [2:0] fifo_level;

   int checks   = 0;
   int failures = 0;

   logic [7:0] got[$];
   int         got_cycle[$];
   logic [2:0] lvl_hist [0:1023];
   logic       rdy_hist [0:1023];
   int         max_level;

   uart_tx_feeder #(
      .DEPTH    (4),
      .BAUD_END (8),
      .BIT_END  (10),
      .GAP_BITS (1)
   ) dut (
      .sclk       (sclk),
      .s_rst      (s_rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_flag    (tx_flag),
      .tx_data    (tx_data),
      .busy       (busy),
      .fifo_level (fifo_level)
   );

   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic do_reset();
      s_rst    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      step();
      step();
      s_rst = 1'b0;
   endtask

   // Offers n bytes base, base+1, ... (only on cycles where t % gap == 0) and records every tx_flag.
   task automatic run_stream(input logic [7:0] base, input int n, input int gap, input int cycles);
      int  idx;
      logic pushed;
      idx = 0;
      got.delete();
      got_cycle.delete();
      max_level = 0;
      for (int t = 0; t < cycles; t++) begin
         if (tx_flag) begin
            got.push_back(tx_data);
            got_cycle.push_back(t);
         end
         if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
         if (t < 1024) begin
            lvl_hist[t] = fifo_level;
            rdy_hist[t] = in_ready;
         end
         in_valid = (idx < n) && ((t % gap) == 0);
         in_data  = base + 8'(idx);
         pushed   = in_valid && in_ready;
         step();
         if (pushed) idx++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (tx_flag !== 1'b0)    begin failures++; $display("FAIL reset_tx_flag got=%b exp=0", tx_flag); end
      checks++; if (tx_data !== 8'h00)   begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
      checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_single();
      logic exp_flag;
      logic exp_busy;
      do_reset();
      for (int t = 0; t < 100; t++) begin
         exp_flag = (t == 4);
         exp_busy = (t >= 2) && (t <= 91);
         checks++; if (tx_flag !== exp_flag) begin failures++; $display("FAIL single_flag t=%0d got=%b exp=%b", t, tx_flag, exp_flag); end
         checks++; if (busy !== exp_busy)    begin failures++; $display("FAIL single_busy t=%0d got=%b exp=%b", t, busy, exp_busy); end
         if (t == 1) begin
            checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL single_level1 got=%0d exp=1", fifo_level); end
         end
         if (t == 2) begin
            checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL single_level2 got=%0d exp=0", fifo_level); end
         end
         if (t == 4) begin
            checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", tx_data); end
         end
         in_valid = (t == 0);
         in_data  = 8'hA5;
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_burst();
      logic       exp_flag;
      logic       exp_change;
      logic       changed;
      logic [7:0] prev;
      do_reset();
      prev = tx_data;
      for (int t = 0; t < 280; t++) begin
         exp_flag   = (t == 4) || (t == 95) || (t == 186);
         exp_change = (t == 3) || (t == 94) || (t == 185);
         changed    = (tx_data !== prev);
         prev       = tx_data;
         checks++; if (tx_flag !== exp_flag)  begin failures++; $display("FAIL burst_flag t=%0d got=%b exp=%b", t, tx_flag, exp_flag); end
         checks++; if (changed !== exp_change) begin failures++; $display("FAIL burst_data_change t=%0d got=%b exp=%b", t, changed, exp_change); end
         if (t == 4) begin
            checks++; if (tx_data !== 8'h01) begin failures++; $display("FAIL burst_data0 got=%h exp=01", tx_data); end
         end
         if (t == 95) begin
            checks++; if (tx_data !== 8'h02) begin failures++; $display("FAIL burst_data1 got=%h exp=02", tx_data); end
         end
         if (t == 186) begin
            checks++; if (tx_data !== 8'h03) begin failures++; $display("FAIL burst_data2 got=%h exp=03", tx_data); end
         end
         in_valid = (t < 3);
         in_data  = 8'(t + 1);
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      run_stream(8'h10, 8, 1, 660);
      checks++; if (lvl_hist[4] !== 3'd3) begin failures++; $display("FAIL full_level4 got=%0d exp=3", lvl_hist[4]); end
      checks++; if (rdy_hist[4] !== 1'b1) begin failures++; $display("FAIL full_ready4 got=%b exp=1", rdy_hist[4]); end
      checks++; if (lvl_hist[5] !== 3'd4) begin failures++; $display("FAIL full_level5 got=%0d exp=4", lvl_hist[5]); end
      checks++; if (rdy_hist[5] !== 1'b0) begin failures++; $display("FAIL full_ready5 got=%b exp=0", rdy_hist[5]); end
      checks++; if (max_level != 4)       begin failures++; $display("FAIL full_max_level got=%0d exp=4", max_level); end
      checks++;
      if (got.size() != 8) begin
         failures++; $display("FAIL full_count got=%0d exp=8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++; if (got[i] !== 8'(8'h10 + i)) begin failures++; $display("FAIL full_order i=%0d got=%h exp=%h", i, got[i], 8'(8'h10 + i)); end
         end
      end
   endtask

   task automatic test_simul();
      int nflags;
      nflags = 0;
      do_reset();
      for (int t = 0; t < 190; t++) begin
         if (tx_flag) nflags++;
         if (t == 92) begin
            checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL simul_idle got=%b exp=0", busy); end
            checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL simul_level_pre got=%0d exp=1", fifo_level); end
         end
         if (t == 93) begin
            checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL simul_level_post got=%0d exp=1", fifo_level); end
         end
         if (t == 95) begin
            checks++; if (tx_flag !== 1'b1)  begin failures++; $display("FAIL simul_flag2 got=%b exp=1", tx_flag); end
            checks++; if (tx_data !== 8'h66) begin failures++; $display("FAIL simul_data2 got=%h exp=66", tx_data); end
         end
         if (t == 186) begin
            checks++; if (tx_flag !== 1'b1)  begin failures++; $display("FAIL simul_flag3 got=%b exp=1", tx_flag); end
            checks++; if (tx_data !== 8'h77) begin failures++; $display("FAIL simul_data3 got=%h exp=77", tx_data); end
         end
         in_valid = (t == 0) || (t == 10) || (t == 92);
         in_data  = (t == 0) ? 8'h55 : ((t == 10) ? 8'h66 : 8'h77);
         step();
      end
      in_valid = 1'b0;
      checks++; if (nflags != 3) begin failures++; $display("FAIL simul_flag_count got=%0d exp=3", nflags); end
   endtask

   task automatic test_wrap();
      do_reset();
      run_stream(8'hA0, 10, 3, 930);
      checks++;
      if (got.size() != 10) begin
         failures++; $display("FAIL wrap_count got=%0d exp=10", got.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            checks++; if (got[i] !== 8'(8'hA0 + i)) begin failures++; $display("FAIL wrap_order i=%0d got=%h exp=%h", i, got[i], 8'(8'hA0 + i)); end
         end
         checks++; if (got_cycle[0] != 4) begin failures++; $display("FAIL wrap_first_flag got=%0d exp=4", got_cycle[0]); end
         for (int i = 0; i < 9; i++) begin
            checks++;
            if (got_cycle[i+1] - got_cycle[i] != 91) begin
               failures++; $display("FAIL wrap_spacing i=%0d got=%0d exp=91", i, got_cycle[i+1] - got_cycle[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int nflags;
      nflags = 0;
      do_reset();
      for (int t = 0; t < 260; t++) begin
         if (t == 20) begin
            checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
            checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL mid_level_before got=%0d exp=2", fifo_level); end
         end
         if (t == 21) begin
            checks++; if (tx_flag !== 1'b0)    begin failures++; $display("FAIL mid_tx_flag got=%b exp=0", tx_flag); end
            checks++; if (tx_data !== 8'h00)   begin failures++; $display("FAIL mid_tx_data got=%h exp=00", tx_data); end
            checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL mid_level got=%0d exp=0", fifo_level); end
            checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
            checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
         end
         if ((t > 21) && tx_flag) nflags++;
         s_rst    = (t == 20);
         in_valid = (t < 3);
         in_data  = 8'(8'h31 + t);
         step();
      end
      s_rst    = 1'b0;
      in_valid = 1'b0;
      checks++; if (nflags != 0) begin failures++; $display("FAIL mid_no_flags got=%0d exp=0", nflags); end
   endtask

   initial begin
      s_rst    = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      test_reset();
      test_single();
      test_burst();
      test_full();
      test_simul();
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
- Byte buffer and pacing stage directly upstream of the UART transmitter.
- Accepts bytes from the system side via a valid/ready handshake and stores them in a FIFO.
- Issues one single-cycle tx_flag per byte and holds tx_data stable for the whole frame. The transmitter has no busy/done output, so this block enforces the frame spacing with its own counter.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- BAUD_END, 5208, clock cycles per UART bit; must equal the transmitter's baud divisor.
- BIT_END, 10, bits per frame (start + 8 data + stop).
- GAP_BITS, 1, extra idle bit periods inserted after each frame.

Ports:
- sclk  in  1  system clock
- s_rst  in  1  synchronous reset, active-high
- in_data  in  8  byte to transmit
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO can accept; equals !full
- tx_flag  out  1  one-cycle start pulse to the transmitter
- tx_data  out  8  byte under transmission; stable from the tx_flag cycle until the next tx_flag
- busy  out  1  high while in LOAD, SEND or WAIT
- fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: one clock, sclk; reset s_rst is synchronous and active-high.
- Reset values: tx_flag=0, tx_data=8'h00, busy=0, fifo_level=0, in_ready=1, FSM=IDLE, pacing counter=0. The FIFO pointers are cleared; stored contents are don't-care.
- Reset mid-frame: immediately returns to IDLE and discards all buffered bytes. The transmitter shares s_rst, so no partial frame is resumed.
- Push: occurs when in_valid && in_ready at a rising edge. fifo_level increments the following cycle.
- Pop: occurs only from the FSM, at most one per frame.
- Simultaneous push and pop: both take effect and fifo_level is unchanged.
- Full: in_ready=0 even if a pop happens in the same cycle, so the block is conservative and never overflows. Writes with in_ready=0 are ignored.
- Empty: pop is never issued.
- Pointers: log2(DEPTH) bits, wrap naturally. fifo_level uses one extra bit so that DEPTH is representable.
- FRAME_CYCLES = BAUD_END*(BIT_END+GAP_BITS); the pacing counter is wide enough to hold FRAME_CYCLES-1.
- FSM states:
  - IDLE: if fifo_level!=0, pop and go to LOAD; else stay.
  - LOAD: register the FIFO head into tx_data; go to SEND.
  - SEND: tx_flag=1 for exactly this cycle; load the counter with FRAME_CYCLES-1; go to WAIT.
  - WAIT: decrement the counter; at 0 go to IDLE.
- Timing:
  - Latency: a byte pushed at edge N into an empty, idle block gives tx_flag high in the cycle after edge N+3.
  - Back-to-back: consecutive tx_flag pulses are exactly FRAME_CYCLES+3 cycles apart when the FIFO stays non-empty.
  - tx_data changes only on the LOAD-to-SEND edge, never during WAIT.
- in_data arriving during WAIT is buffered normally and does not disturb the current frame.

Decomposition:
- Shared include uart_defs.vh holds:
  - BAUD_END, BIT_END and GAP_BITS defaults, common with the transmitter.
  - FRAME_CYCLES derivation.
  - FSM state encodings (IDLE=2'd0, LOAD=2'd1, SEND=2'd2, WAIT=2'd3).
- One sub-module, sync_fifo:
  - Parameterised by width and depth; single clock, synchronous active-high reset.
  - Outputs full, empty and level.
  - Registered read data valid the cycle after rd_en.
- The top level is the FSM plus the pacing counter.

Test Plan (use BAUD_END=8, BIT_END=10, GAP_BITS=1, so FRAME_CYCLES=88; DEPTH=4):
- Single byte: push 8'hA5 at cycle 0 -> tx_flag one cycle high at cycle 4 with tx_data=8'hA5; busy high cycles 2..91; IDLE with busy=0 from cycle 92.
- Burst: push 8'h01,02,03 on consecutive cycles -> tx_flag at 4, 95, 186 with tx_data 01, 02, 03; tx_data never changes between pulses.
- Full: hold in_valid with bytes 10..17 while the transmitter drains -> in_ready drops once fifo_level=4; output order is exactly 10..17 with no loss or duplication; blocked cycles do not advance the write pointer.
- Simultaneous push and pop: push in the cycle IDLE pops with fifo_level=1 -> fifo_level stays 1; next frame sends the new byte.
- Wrap: send 10 bytes through DEPTH=4 -> pointer wrap is transparent; all 10 bytes are emitted in order.
- Reset mid-frame: assert s_rst for 1 cycle during WAIT with 2 bytes queued -> next cycle tx_flag=0, tx_data=0, fifo_level=0, in_ready=1, busy=0; no further tx_flag without new pushes.
